// File: rtl/schoolbook_div.sv
// rtl/schoolbook_div.sv - restoring shift-and-subtract divider, 2N-bit by N-bit, one quotient bit per clock
module schoolbook_div #(
    parameter int N = 384
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] q,
    output logic [N-1:0]   r,
    output logic           dz
);
    localparam int CW = $clog2(2*N+1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    logic [2*N-1:0] r_dvd;
    logic [N-1:0]   r_div;
    logic [N-1:0]   r_alo;
    logic [N-1:0]   r_rem;
    logic [2*N-1:0] r_q;
    logic [N-1:0]   r_r;
    logic           r_dz;

    logic           w_accept;
    logic           w_last;
    logic [N:0]     w_t;
    logic           w_ge;
    logic [N-1:0]   w_diff;
    logic [N-1:0]   w_rem_next;
    logic [2*N-1:0] w_dvd_next;

    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(2*N-1));

    assign w_t        = {r_rem, r_dvd[2*N-1]};
    assign w_ge       = (w_t >= {1'b0, r_div});
    // Whenever t >= divisor the true difference is below the divisor, so the low N bits are exact.
    assign w_diff     = w_t[N-1:0] - r_div;
    assign w_rem_next = w_ge ? w_diff : w_t[N-1:0];
    assign w_dvd_next = {r_dvd[2*N-2:0], w_ge};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_dvd <= '0;
            r_div <= '0;
            r_alo <= '0;
            r_rem <= '0;
            r_q   <= '0;
            r_r   <= '0;
            r_dz  <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_dvd <= a;
            r_div <= b;
            r_alo <= a[N-1:0];
            r_rem <= '0;
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + CW'(1);
            r_dvd <= w_dvd_next;
            r_rem <= w_rem_next;
            if (w_last) begin
                if (r_div == '0) begin
                    r_q  <= '1;
                    r_r  <= r_alo;
                    r_dz <= 1'b1;
                end else begin
                    r_q  <= w_dvd_next;
                    r_r  <= w_rem_next;
                    r_dz <= 1'b0;
                end
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign q    = r_q;
    assign r    = r_r;
    assign dz   = r_dz;
endmodule
